// File: rtl/seg7_scan_display.sv
// 4-digit multiplexed common-anode 7-segment driver: sequential binary-to-BCD
// (shift-add-3) feeding a free-running digit scanner with leading-zero blanking.
module seg7_scan_display #(
    parameter int WIDTH       = 8,
    parameter int REFRESH_DIV = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value_i,
    input  logic             load_i,
    output logic             busy_o,
    output logic [6:0]       seg_o,
    output logic [3:0]       an_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [15:0]      disp;
    logic [WIDTH-1:0] bin;
    logic [CW-1:0]    bit_cnt;

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            bcd     <= '0;
            bin     <= '0;
            bit_cnt <= '0;
            disp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_i) begin
                        bin     <= value_i;
                        bcd     <= '0;
                        bit_cnt <= CW'(WIDTH);
                        busy_o  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd     <= {bcd_adj[14:0], bin[WIDTH-1]};
                    bin     <= {bin[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt - CW'(1);
                    if (bit_cnt == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    disp   <= bcd;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    logic [RW-1:0] rcnt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic          wrap;
    logic [3:0]    nib;
    logic          blank;

    assign wrap    = (rcnt == RW'(REFRESH_DIV - 1));
    assign idx_nxt = wrap ? idx + 2'd1 : idx;
    assign nib     = disp[4*idx_nxt +: 4];

    // Digit k blanks when it and every higher digit are zero; digit 0 never blanks.
    always_comb begin
        case (idx_nxt)
            2'd3:    blank = (disp[15:12] == 4'd0);
            2'd2:    blank = (disp[15:8]  == 8'd0);
            2'd1:    blank = (disp[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
    end

    // Outputs are registered from the upcoming index so they land one cycle after the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt  <= '0;
            idx   <= 2'd0;
            an_o  <= 4'b1110;
            seg_o <= 7'h40;
        end else begin
            rcnt  <= wrap ? '0 : rcnt + RW'(1);
            idx   <= idx_nxt;
            an_o  <= ~(4'b0001 << idx_nxt);
            seg_o <= blank ? 7'h7F : decode(nib);
        end
    end
endmodule
